// File: rtl/arith_pkg.sv
// Shared arithmetic datapath types and width helpers.
// Used by the sequential multiplier and divider blocks.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_state_t;

  // Width of a counter that must hold values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One shift-and-add iteration: conditional add of the
// multiplicand into the upper half, then a right shift.
module shift_add_step #(
  parameter int N = 4
) (
  input  logic [2*N:0] acc,
  input  logic [N-1:0] mcand,
  output logic [2*N:0] acc_next
);

  logic [N:0]   sum;
  logic [2*N:0] pre;

  always_comb begin
    // N+1-bit add so the carry lands in acc[2N].
    sum      = {1'b0, acc[2*N-1:N]} + {1'b0, mcand};
    pre      = acc[0] ? {sum, acc[N-1:0]} : acc;
    acc_next = pre >> 1;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N multiplier, one
// multiplier bit per clock, start/done handshake.
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mul_state_t state, state_n;

  logic [2*N:0]   acc, acc_n, acc_step;
  logic [N-1:0]   mcand_r, mcand_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2*N-1:0] prod_n;
  logic           busy_n, done_n;

  shift_add_step #(.N(N)) u_step (
    .acc      (acc),
    .mcand    (mcand_r),
    .acc_next (acc_step)
  );

  always_comb begin
    state_n = state;
    acc_n   = acc;
    mcand_n = mcand_r;
    cnt_n   = cnt;
    prod_n  = product;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = CALC;
          mcand_n = multiplicand;
          acc_n   = {{(N+1){1'b0}}, multiplier};
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        acc_n = acc_step;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          prod_n  = acc_step[2*N-1:0];
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Status flags are registered from the next state.
    busy_n = (state_n == CALC);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand_r <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      mcand_r <= mcand_n;
      cnt     <= cnt_n;
      product <= prod_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed timing steps at N=4,
// exhaustive N=4 sweep and random N=8 pairs vs a*b.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s4, s8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  shift_add_multiplier #(.N(4)) u4 (
    .clk          (clk),
    .rst          (rst),
    .start        (s4),
    .multiplicand (a4),
    .multiplier   (b4),
    .busy         (busy4),
    .done         (done4),
    .product      (p4)
  );

  shift_add_multiplier #(.N(8)) u8 (
    .clk          (clk),
    .rst          (rst),
    .start        (s8),
    .multiplicand (a8),
    .multiplier   (b8),
    .busy         (busy8),
    .done         (done8),
    .product      (p8)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Start one N=4 op; lat = negedges until done seen.
  task automatic go4(input logic [3:0] a,
                     input logic [3:0] b,
                     output int lat);
    lat = -1;
    a4 = a; b4 = b; s4 = 1'b1;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      @(negedge clk);
      s4 = 1'b0;
      if (done4) lat = i;
    end
  endtask

  task automatic run4(input logic [3:0] a,
                      input logic [3:0] b,
                      input string tag);
    int lat;
    int exp;
    exp = int'(a) * int'(b);
    go4(a, b, lat);
    chk({tag, " latency"}, lat, 5);
    chk({tag, " product"}, p4, exp);
    @(negedge clk);
    chk({tag, " done low"}, done4, 0);
  endtask

  task automatic run8(input logic [7:0] a,
                      input logic [7:0] b,
                      input string tag);
    int lat;
    int exp;
    exp = int'(a) * int'(b);
    lat = -1;
    a8 = a; b8 = b; s8 = 1'b1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      s8 = 1'b0;
      if (done8) lat = i;
    end
    chk({tag, " latency"}, lat, 9);
    chk({tag, " product"}, p8, exp);
    @(negedge clk);
    chk({tag, " done low"}, done8, 0);
  endtask

  initial begin
    int lat, nbusy, ndone;
    logic [7:0] seen;

    rst = 1'b1; s4 = 1'b0; s8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy4, 0);
    chk("reset done", done4, 0);
    chk("reset product", p4, 0);
    chk("reset product8", p8, 0);
    rst = 1'b0;
    @(negedge clk);

    // 13 x 11: busy for 4 cycles, single done.
    a4 = 4'd13; b4 = 4'd11; s4 = 1'b1;
    nbusy = 0; ndone = 0; lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      s4 = 1'b0;
      if (busy4) nbusy++;
      if (done4) begin
        ndone++;
        if (lat < 0) lat = i;
        chk("13x11 product", p4, 143);
        chk("13x11 busy at done", busy4, 0);
      end
    end
    chk("13x11 busy cycles", nbusy, 4);
    chk("13x11 done count", ndone, 1);
    chk("13x11 latency", lat, 5);
    repeat (5) @(negedge clk);
    chk("13x11 product held", p4, 143);

    run4(4'd15, 4'd15, "15x15");
    run4(4'd0, 4'd9, "0x9");

    // start mid-CALC must be ignored.
    a4 = 4'd7; b4 = 4'd6; s4 = 1'b1;
    ndone = 0; seen = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      s4 = 1'b0;
      if (i == 2) begin
        a4 = 4'd3; b4 = 4'd3; s4 = 1'b1;
      end
      if (done4) begin
        ndone++;
        seen = p4;
      end
    end
    chk("ignore product", seen, 42);
    chk("ignore done count", ndone, 1);

    // Back-to-back: restart during the DONE cycle.
    go4(4'd5, 4'd5, lat);
    chk("b2b first latency", lat, 5);
    chk("b2b first product", p4, 25);
    go4(4'd9, 4'd2, lat);
    chk("b2b second latency", lat, 5);
    chk("b2b second product", p4, 18);
    @(negedge clk);

    // Reset mid-CALC, with start asserted alongside.
    a4 = 4'd12; b4 = 4'd12; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    a4 = 4'd1; b4 = 4'd1; s4 = 1'b1;
    @(negedge clk);
    rst = 1'b0; s4 = 1'b0;
    chk("rst busy", busy4, 0);
    chk("rst done", done4, 0);
    chk("rst product", p4, 0);
    ndone = 0; nbusy = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4) ndone++;
      if (busy4) nbusy++;
    end
    chk("rst no done", ndone, 0);
    chk("rst no busy", nbusy, 0);
    run4(4'd2, 4'd3, "after rst 2x3");

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run4(4'(a), 4'(b), $sformatf("sweep %0dx%0d", a, b));

    run8(8'd255, 8'd255, "n8 255x255");
    run8(8'd0, 8'd200, "n8 0x200");
    for (int k = 0; k < 40; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      run8(ra, rb, $sformatf("n8 %0dx%0d", ra, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
